// File: rtl/xgmac_mdio_master_if.sv
// Request/response handshake between host logic and the MDIO master.
interface xgmac_mdio_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_prtad;
    logic [4:0]  req_devad;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;

    // Host side issues requests and consumes responses.
    modport master (
        output req_valid, req_op, req_prtad, req_devad, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // MDIO master side accepts requests and produces responses.
    modport slave (
        input  req_valid, req_op, req_prtad, req_devad, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/xgmac_mdio_master.sv
// Clause-45 MDIO initiator: frames address/write/read/post-read-increment ops onto MDC/MDIO.
module xgmac_mdio_master #(
    parameter int unsigned C_MDC_DIV = 32,
    parameter int unsigned C_PRE_LEN = 32
) (
    input  logic                      clk156,
    input  logic                      reset,
    xgmac_mdio_master_if.slave        bus,
    output logic                      mdc,
    output logic                      mdio_out,
    output logic                      mdio_tri,
    input  logic                      mdio_in
);

    typedef enum logic [2:0] {StIdle, StPre, StHdr, StTa, StData, StDone} state_e;

    localparam logic [7:0] DivLast = 8'(C_MDC_DIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        mdc_q, mdc_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  op_q;
    logic [4:0]  prtad_q, devad_q;
    logic [15:0] data_q;
    logic [15:0] shift_q, shift_d;
    logic        err_q, err_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        out_q, out_d, tri_q, tri_d;

    logic        accept, in_frame, phase_end, rise, bit_end, last_bit;
    logic [1:0]  op_src;
    logic [13:0] hdr_src;
    logic [15:0] data_src;
    logic [3:0]  bit_idx;

    function automatic logic [5:0] state_len(state_e s);
        case (s)
            StPre:   return 6'(C_PRE_LEN);
            StHdr:   return 6'd14;
            StTa:    return 6'd2;
            StData:  return 6'd16;
            default: return 6'd0;
        endcase
    endfunction

    assign accept    = bus.req_valid && (state_q == StIdle);
    assign in_frame  = (state_q == StPre) || (state_q == StHdr) ||
                       (state_q == StTa)  || (state_q == StData);
    assign phase_end = in_frame && (div_q == DivLast);
    assign rise      = phase_end && !mdc_q;
    assign bit_end   = phase_end && mdc_q;
    assign last_bit  = bit_end && (bit_cnt_q == 6'd1);

    // On the acceptance cycle the first bit is built from the bus, not the latched copy.
    assign op_src   = accept ? bus.req_op : op_q;
    assign hdr_src  = accept ? {2'b00, bus.req_op, bus.req_prtad, bus.req_devad}
                             : {2'b00, op_q, prtad_q, devad_q};
    assign data_src = accept ? bus.req_data : data_q;
    assign bit_idx  = 4'(bit_cnt_d - 6'd1);

    // State register.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: each frame field advances after its last bit's high phase.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = (C_PRE_LEN > 0) ? StPre : StHdr;
            StPre:  if (last_bit) state_d = StHdr;
            StHdr:  if (last_bit) state_d = StTa;
            StTa:   if (last_bit) state_d = StData;
            StData: if (last_bit) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs and datapath next-state.
    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.rsp_valid = (state_q == StDone);
        bus.rsp_data  = rsp_data_q;
        bus.rsp_err   = err_q;
        mdc           = mdc_q;
        mdio_out      = out_q;
        mdio_tri      = tri_q;

        div_d = 8'd0;
        mdc_d = 1'b0;
        if (in_frame) begin
            div_d = phase_end ? 8'd0 : div_q + 8'd1;
            mdc_d = phase_end ? ~mdc_q : mdc_q;
        end

        bit_cnt_d = bit_cnt_q;
        if (accept || last_bit) begin
            bit_cnt_d = state_len(state_d);
        end else if (bit_end) begin
            bit_cnt_d = bit_cnt_q - 6'd1;
        end

        // MDIO only changes at the start of a low phase.
        out_d = out_q;
        tri_d = tri_q;
        if (accept || bit_end) begin
            unique case (state_d)
                StPre: begin
                    out_d = 1'b1;
                    tri_d = 1'b0;
                end
                StHdr: begin
                    out_d = hdr_src[bit_idx];
                    tri_d = 1'b0;
                end
                StTa: begin
                    out_d = op_src[1] ? 1'b1 : bit_cnt_d[1];
                    tri_d = op_src[1];
                end
                StData: begin
                    out_d = op_src[1] ? 1'b1 : data_src[bit_idx];
                    tri_d = op_src[1];
                end
                default: begin
                    out_d = 1'b1;
                    tri_d = 1'b1;
                end
            endcase
        end

        shift_d = shift_q;
        if (accept) begin
            shift_d = 16'd0;
        end else if (rise && (state_q == StData)) begin
            shift_d = {shift_q[14:0], mdio_in};
        end

        // A released second TA bit means nobody answered the read.
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (rise && (state_q == StTa) && (bit_cnt_q == 6'd1) && op_q[1] && mdio_in) begin
            err_d = 1'b1;
        end

        rsp_data_d = rsp_data_q;
        if (last_bit && (state_q == StData)) begin
            rsp_data_d = op_q[1] ? shift_q : 16'd0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            div_q      <= 8'd0;
            mdc_q      <= 1'b0;
            bit_cnt_q  <= 6'd0;
            op_q       <= 2'd0;
            prtad_q    <= 5'd0;
            devad_q    <= 5'd0;
            data_q     <= 16'd0;
            shift_q    <= 16'd0;
            err_q      <= 1'b0;
            rsp_data_q <= 16'd0;
            out_q      <= 1'b1;
            tri_q      <= 1'b1;
        end else begin
            div_q      <= div_d;
            mdc_q      <= mdc_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            err_q      <= err_d;
            rsp_data_q <= rsp_data_d;
            out_q      <= out_d;
            tri_q      <= tri_d;
            if (accept) begin
                op_q    <= bus.req_op;
                prtad_q <= bus.req_prtad;
                devad_q <= bus.req_devad;
                data_q  <= bus.req_data;
            end
        end
    end

endmodule

// File: tb/tb_xgmac_mdio_master.sv
// Scoreboard bench for the MDIO master: one instance with preamble, one without.
module tb_xgmac_mdio_master;

    localparam int unsigned DIV   = 2;
    localparam int unsigned LAT_A = (32 + 32) * 2 * DIV + 1;
    localparam int unsigned LAT_B = (0 + 32) * 2 * DIV + 1;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic [63:0] out;
        logic [63:0] trs;
        logic [63:0] resp;
    } exp_t;

    logic        clk156 = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk156 = ~clk156;
    always @(posedge clk156) cyc <= cyc + 1;

    xgmac_mdio_master_if a_if ();
    xgmac_mdio_master_if b_if ();
    logic a_mdc, a_out, a_trs;
    logic a_in = 1'b1;
    logic b_mdc, b_out, b_trs;
    logic b_in = 1'b1;

    xgmac_mdio_master #(.C_MDC_DIV(DIV), .C_PRE_LEN(32)) dut (
        .clk156(clk156), .reset(reset), .bus(a_if.slave),
        .mdc(a_mdc), .mdio_out(a_out), .mdio_tri(a_trs), .mdio_in(a_in)
    );

    xgmac_mdio_master #(.C_MDC_DIV(DIV), .C_PRE_LEN(0)) dut_b (
        .clk156(clk156), .reset(reset), .bus(b_if.slave),
        .mdc(b_mdc), .mdio_out(b_out), .mdio_tri(b_trs), .mdio_in(b_in)
    );

    exp_t a_q[$];
    exp_t b_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Instance A monitor: captures bits at MDC rise, plays responder, scores responses.
    exp_t        a_e;
    logic        a_prev = 1'b0;
    int unsigned a_nrise = 0, a_acc = 0, a_rsp_cyc = 0, a_gap = 0, a_rise_cyc = 0, a_period = 0;
    logic [63:0] a_cap_out = '0, a_cap_trs = '0, a_resp = '1;
    always @(negedge clk156) begin
        if (reset) begin
            a_prev  = 1'b0;
            a_nrise = 0;
            a_in    = 1'b1;
        end else begin
            if (a_mdc && !a_prev) begin
                a_cap_out  = {a_cap_out[62:0], a_out};
                a_cap_trs  = {a_cap_trs[62:0], a_trs};
                a_nrise++;
                a_period   = cyc - a_rise_cyc;
                a_rise_cyc = cyc;
                a_in       = (a_nrise < 64) ? a_resp[63 - a_nrise] : 1'b1;
            end
            a_prev = a_mdc;
            if (a_if.rsp_valid) begin
                a_rsp_cyc = cyc;
                chk("a_rsp_expected", a_q.size() != 0, 1);
                if (a_q.size() != 0) begin
                    a_e = a_q.pop_front();
                    chk("a_rsp_data", a_if.rsp_data, a_e.data);
                    chk("a_rsp_err", a_if.rsp_err, a_e.err);
                    chk("a_latency", cyc - a_acc, LAT_A);
                    chk("a_bit_count", a_nrise, 64);
                    chk("a_mdio_out_stream", a_cap_out, a_e.out);
                    chk("a_mdio_tri_stream", a_cap_trs, a_e.trs);
                end
            end
            if (a_if.req_valid && a_if.req_ready) begin
                a_gap     = cyc - a_rsp_cyc;
                a_acc     = cyc;
                a_nrise   = 0;
                a_cap_out = '0;
                a_cap_trs = '0;
                a_resp    = (a_q.size() != 0) ? a_q[0].resp : '1;
                a_in      = a_resp[63];
            end
        end
    end

    // Instance B monitor (no preamble, 32-bit frame).
    exp_t        b_e;
    logic        b_prev = 1'b0;
    int unsigned b_nrise = 0, b_acc = 0;
    logic [31:0] b_cap_out = '0, b_cap_trs = '0;
    always @(negedge clk156) begin
        if (reset) begin
            b_prev  = 1'b0;
            b_nrise = 0;
        end else begin
            if (b_mdc && !b_prev) begin
                b_cap_out = {b_cap_out[30:0], b_out};
                b_cap_trs = {b_cap_trs[30:0], b_trs};
                b_nrise++;
            end
            b_prev = b_mdc;
            if (b_if.rsp_valid) begin
                chk("b_rsp_expected", b_q.size() != 0, 1);
                if (b_q.size() != 0) begin
                    b_e = b_q.pop_front();
                    chk("b_rsp_data", b_if.rsp_data, b_e.data);
                    chk("b_rsp_err", b_if.rsp_err, b_e.err);
                    chk("b_latency", cyc - b_acc, LAT_B);
                    chk("b_bit_count", b_nrise, 32);
                    chk("b_mdio_out_stream", b_cap_out, b_e.out);
                    chk("b_mdio_tri_stream", b_cap_trs, b_e.trs);
                end
            end
            if (b_if.req_valid && b_if.req_ready) begin
                b_acc     = cyc;
                b_nrise   = 0;
                b_cap_out = '0;
                b_cap_trs = '0;
            end
        end
    end

    task automatic expect_a(input logic [1:0] op, input logic [4:0] prtad, input logic [4:0] devad,
                            input logic [15:0] data, input logic [63:0] resp);
        exp_t e;
        logic rd;
        rd     = op[1];
        e.out  = {32'hFFFF_FFFF, 2'b00, op, prtad, devad, rd ? 2'b11 : 2'b10,
                  rd ? 16'hFFFF : data};
        e.trs  = rd ? {46'd0, 18'h3FFFF} : 64'd0;
        e.data = rd ? resp[15:0] : 16'h0000;
        e.err  = rd ? resp[16] : 1'b0;
        e.resp = resp;
        a_q.push_back(e);
    endtask

    task automatic send_a(input logic [1:0] op, input logic [4:0] prtad, input logic [4:0] devad,
                          input logic [15:0] data, input bit hold);
        int n;
        a_if.req_op    = op;
        a_if.req_prtad = prtad;
        a_if.req_devad = devad;
        a_if.req_data  = data;
        a_if.req_valid = 1'b1;
        n = 0;
        while (!a_if.req_ready && n < 1000) begin
            @(posedge clk156); #1;
            n++;
        end
        chk("a_accept_in_time", n < 1000, 1);
        @(posedge clk156); #1;
        chk("a_ready_drops", a_if.req_ready, 0);
        if (!hold) begin
            a_if.req_valid = 1'b0;
            a_if.req_op    = 2'($urandom);
            a_if.req_prtad = 5'($urandom);
            a_if.req_devad = 5'($urandom);
            a_if.req_data  = 16'($urandom);
        end
    endtask

    task automatic wait_a();
        int n;
        n = 0;
        while (a_q.size() != 0 && n < 2000) begin
            @(posedge clk156); #1;
            n++;
        end
        chk("a_rsp_in_time", a_q.size(), 0);
    endtask

    initial begin
        int  n;
        exp_t eb;
        reset = 1'b1;
        a_if.req_valid = 1'b0; a_if.req_op = 2'd0; a_if.req_prtad = 5'd0;
        a_if.req_devad = 5'd0; a_if.req_data = 16'd0;
        b_if.req_valid = 1'b0; b_if.req_op = 2'd0; b_if.req_prtad = 5'd0;
        b_if.req_devad = 5'd0; b_if.req_data = 16'd0;
        repeat (3) @(posedge clk156);
        #1;
        chk("a_reset_ctrl", {a_if.req_ready, a_if.rsp_valid, a_if.rsp_err, a_mdc, a_out, a_trs},
            6'b100011);
        chk("a_reset_rsp_data", a_if.rsp_data, 0);
        chk("b_reset_ctrl", {b_if.req_ready, b_if.rsp_valid, b_if.rsp_err, b_mdc, b_out, b_trs},
            6'b100011);
        reset = 1'b0;
        repeat (2) @(posedge clk156);
        #1;

        // Write with preamble.
        expect_a(2'b01, 5'd0, 5'd1, 16'hA5C3, '1);
        send_a(2'b01, 5'd0, 5'd1, 16'hA5C3, 1'b0);
        wait_a();
        chk("a_mdc_period", a_period, 2 * DIV);
        chk("a_idle_after_done", {a_if.req_ready, a_mdc, a_out, a_trs}, 4'b1011);

        // Read with a responder answering 0x2040.
        expect_a(2'b11, 5'd3, 5'd3, 16'h0000, {{46{1'b1}}, 2'b10, 16'h2040});
        send_a(2'b11, 5'd3, 5'd3, 16'h0000, 1'b0);
        wait_a();

        // Read with nobody on the bus.
        expect_a(2'b11, 5'd7, 5'd30, 16'h0000, '1);
        send_a(2'b11, 5'd7, 5'd30, 16'h0000, 1'b0);
        wait_a();

        // Post-read-increment read; error flag from the previous read must be cleared.
        expect_a(2'b10, 5'd31, 5'd4, 16'hFFFF, {{46{1'b1}}, 2'b00, 16'h1234});
        send_a(2'b10, 5'd31, 5'd4, 16'hFFFF, 1'b0);
        wait_a();

        // A request pulse mid-frame is dropped.
        expect_a(2'b00, 5'd9, 5'd17, 16'h8001, '1);
        send_a(2'b00, 5'd9, 5'd17, 16'h8001, 1'b0);
        n = 0;
        while (a_nrise < 10 && n < 1000) begin
            @(posedge clk156); #1;
            n++;
        end
        a_if.req_op = 2'b01; a_if.req_data = 16'hDEAD; a_if.req_valid = 1'b1;
        chk("a_busy_not_ready", a_if.req_ready, 0);
        @(posedge clk156); #1;
        a_if.req_valid = 1'b0;
        wait_a();
        repeat (300) @(posedge clk156);
        #1;
        chk("a_busy_pulse_ignored", a_if.rsp_data, 0);

        // Back-to-back with req_valid held high.
        expect_a(2'b01, 5'd1, 5'd2, 16'h1111, '1);
        expect_a(2'b11, 5'd4, 5'd5, 16'h0000, {{46{1'b1}}, 2'b10, 16'h5A5A});
        send_a(2'b01, 5'd1, 5'd2, 16'h1111, 1'b1);
        a_if.req_op = 2'b11; a_if.req_prtad = 5'd4; a_if.req_devad = 5'd5;
        a_if.req_data = 16'($urandom);
        n = 0;
        while (!a_if.req_ready && n < 1000) begin
            @(posedge clk156); #1;
            n++;
        end
        @(posedge clk156); #1;
        a_if.req_valid = 1'b0;
        wait_a();
        chk("a_b2b_gap", a_gap, 1);

        // Reset in the middle of a read's data phase.
        expect_a(2'b11, 5'd3, 5'd3, 16'h0000, '1);
        send_a(2'b11, 5'd3, 5'd3, 16'h0000, 1'b0);
        n = 0;
        while (a_nrise < 40 && n < 1000) begin
            @(posedge clk156); #1;
            n++;
        end
        chk("a_reached_bit40", a_nrise >= 40, 1);
        reset = 1'b1;
        #1;
        chk("a_abort_ctrl", {a_if.req_ready, a_if.rsp_valid, a_if.rsp_err, a_mdc, a_out, a_trs},
            6'b100011);
        chk("a_abort_rsp_data", a_if.rsp_data, 0);
        void'(a_q.pop_front());
        repeat (2) @(posedge clk156);
        #1;
        reset = 1'b0;
        @(posedge clk156); #1;
        expect_a(2'b01, 5'd6, 5'd8, 16'h0F0F, '1);
        send_a(2'b01, 5'd6, 5'd8, 16'h0F0F, 1'b0);
        wait_a();

        // No-preamble instance: address op.
        eb.out  = {32'd0, 2'b00, 2'b00, 5'd2, 5'd1, 2'b10, 16'h0020};
        eb.trs  = 64'd0;
        eb.data = 16'h0000;
        eb.err  = 1'b0;
        eb.resp = '1;
        b_q.push_back(eb);
        b_if.req_op = 2'b00; b_if.req_prtad = 5'd2; b_if.req_devad = 5'd1;
        b_if.req_data = 16'h0020; b_if.req_valid = 1'b1;
        @(posedge clk156); #1;
        b_if.req_valid = 1'b0;
        chk("b_ready_drops", b_if.req_ready, 0);
        n = 0;
        while (b_q.size() != 0 && n < 1000) begin
            @(posedge clk156); #1;
            n++;
        end
        chk("b_rsp_in_time", b_q.size(), 0);

        repeat (10) @(posedge clk156);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xgmac_mdio_master.md
Name: xgmac_mdio_master

Overview:
- Clause-45 MDIO management initiator in the clk156 domain. Host logic (training/bring-up FSM, register bridge) uses it to issue address, write, read and post-read-increment frames to the 10GBASE-R PHY's MDIO responder.
- Generates MDC, drives and tristates MDIO, and returns read data with a one-cycle response strobe.
- Pairs with the PHY management responder on the same mdc / mdio_in / mdio_out / mdio_tri nets.

Parameters:
- C_MDC_DIV, 32: clk156 cycles per MDC half-period. 156.25 MHz / 64 = 2.44 MHz. Legal range 2..255.
- C_PRE_LEN, 32: preamble length in MDC bits, all ones. Legal range 0..32; 0 suppresses the preamble.

Ports:
- clk156  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request strobe.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_op  input  2  00 = address, 01 = write, 11 = read, 10 = post-read-increment read.
- req_prtad  input  5  port address.
- req_devad  input  5  device address.
- req_data  input  16  register address (op 00) or write data (op 01); ignored for reads.
- rsp_valid  output  1  one-cycle completion pulse for every op.
- rsp_data  output  16  read data; 0 for op 00/01; held until the next rsp_valid.
- rsp_err  output  1  qualified by rsp_valid; 1 = no responder (TA bit 2 sampled high) on a read.
- mdc  output  1  management clock.
- mdio_out  output  1  serial data out.
- mdio_tri  output  1  1 = MDIO released (high-Z); 0 = driven.
- mdio_in  input  1  serial data in.

Behaviour:
- Reset values, asserted asynchronously: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, mdc=0, mdio_out=1, mdio_tri=1, state=IDLE, all counters 0.
- Reset mid-frame: aborts immediately, returns to IDLE, no rsp_valid.
- On acceptance, req_* fields are latched; req_ready drops on the next cycle. Request fields may change after acceptance.
- Frame bit order, MSB first: C_PRE_LEN ones, ST=00, OP[1:0], PRTAD[4:0], DEVAD[4:0], TA, 16 data bits.
- MDC timing:
  - A divide counter runs only outside IDLE.
  - mdc is low for C_MDC_DIV cycles, then high for C_MDC_DIV cycles per bit.
  - The first bit's low phase starts the cycle after acceptance; mdc is idle-low.
  - mdio_out/mdio_tri update only at the start of a low phase (MDC falling edge, or frame start).
  - mdio_in is sampled on the clk156 cycle in which mdc goes 0→1.
- FSM:
  - IDLE → PRE when C_PRE_LEN>0, else → HDR.
  - PRE (C_PRE_LEN bits, drive 1) → HDR.
  - HDR (14 bits: ST, OP, PRTAD, DEVAD) → TA.
  - TA (2 bits) → DATA.
  - DATA (16 bits) → DONE.
  - DONE (1 cycle): rsp_valid=1, → IDLE with req_ready=1 the following cycle.
- Bit counter is 6 bits; it reloads per state and decrements at each bit end (the falling edge after the high phase).
- Write/address ops:
  - TA drives 1,0 with mdio_tri=0.
  - DATA drives req_data with mdio_tri=0.
- Read ops (op[1]=1):
  - mdio_tri=1 from the first TA bit through the end of DATA; mdio_out=1.
  - TA bit 2 sample = 1 sets rsp_err.
  - DATA samples shift into a 16-bit register MSB first, copied to rsp_data in DONE.
  - rsp_err is cleared at each new acceptance.
- After DONE: mdio_tri=1, mdio_out=1, mdc=0.
- Frame duration: (C_PRE_LEN+32) × 2 × C_MDC_DIV clk156 cycles from acceptance to the end of the last high phase. rsp_valid follows on the next cycle.
- req_valid while busy is ignored, not queued.
- Back-to-back requests: if req_valid is held, the next request is accepted on the first IDLE cycle after DONE.

Test Plan:
- C_MDC_DIV=2, C_PRE_LEN=32; write prtad=0, devad=1, data=0xA5C3 → mdio_out stream is 32 ones, then 00 01 00000 00001 10 1010010111000011.
  - mdio_tri=0 throughout; mdc period 4 cycles.
  - rsp_valid pulses 256 cycles after acceptance, +1; rsp_data=0.
- Read op=11, prtad=3, devad=3; responder drives TA 0 then 0x2040 → mdio_tri=1 from TA to end of frame; rsp_data=0x2040; rsp_err=0.
- Read with mdio_in held high (no PHY) → rsp_data=0xFFFF, rsp_err=1.
- C_PRE_LEN=0; address op, data=0x0020 → first driven bits are ST 00; frame is 32 MDC cycles; rsp_valid after 128 cycles.
- Reset asserted at bit 40 of a read, then released → outputs return to reset values in the same cycle; no rsp_valid; the next request completes normally.
- req_valid held with two requests queued by the host → second acceptance occurs exactly 1 cycle after the first rsp_valid; req_valid pulses during the busy period are ignored.
